// File: rtl/dec_entry_pkg.sv
// Shared types and helpers for the decimal operand-entry block.
package dec_entry_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam logic [3:0] DEC_MAX = 4'd9;

  // v*10 + d using shifts only; callers truncate to their own result width.
  function automatic logic [15:0] mul10_add(input logic [15:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + {12'd0, d};
  endfunction

endpackage

// File: rtl/dec_entry_key_edge.sv
// Push-button conditioning: 2-flop synchronizer and one-shot press pulse.
// Define DEC_ENTRY_DEBOUNCE_EN to require DEB_CYCLES stable-low samples first.
module key_edge #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_n,
  output logic press
);

  logic [1:0] sync_q, sync_d;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("key_edge: DEB_CYCLES must be at least 1");
  end

  always_comb sync_d = {sync_q[0], key_n};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) sync_q <= 2'b11;
    else          sync_q <= sync_d;
  end

`ifdef DEC_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks one past the hit value so a held key fires only once.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[1])             cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign press = (cnt_q == CNT_HIT);
`else
  logic prev_q, prev_d;

  always_comb prev_d = sync_q[1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) prev_q <= 1'b1;
    else          prev_q <= prev_d;
  end

  assign press = prev_q & ~sync_q[1];
`endif

endmodule

// File: rtl/dec_entry.sv
// Decimal operand entry: accumulates NDIGITS BCD digits MSD-first into a binary
// value offered on a valid/ready handshake. Optional macro: DEC_ENTRY_DEBOUNCE_EN.
module dec_entry
  import dec_entry_pkg::*;
#(
  parameter int NDIGITS    = 2,
  parameter int VAL_W      = 7,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic [3:0]                   digit,
  input  logic                         key_n,
  input  logic                         clear,
  input  logic                         out_ready,
  output logic [VAL_W-1:0]             value,
  output logic                         out_valid,
  output logic [$clog2(NDIGITS+1)-1:0] count,
  output logic                         err
);

  localparam int CW = $clog2(NDIGITS + 1);

  if (NDIGITS < 1 || NDIGITS > 3 || (2 ** VAL_W) <= (10 ** NDIGITS) - 1 || VAL_W > 16)
  begin : g_bad_param
    $error("dec_entry: illegal NDIGITS/VAL_W combination");
  end

  state_e           state_q, state_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic             press;

  key_edge #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_edge (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .key_n   (key_n),
    .press   (press)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear) begin
      state_d = COLLECT;
      value_d = '0;
      count_d = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (press) begin
            if (digit <= DEC_MAX) begin
              value_d = VAL_W'(mul10_add(16'(value_q), digit));
              count_d = count_q + CW'(1);
              err_d   = 1'b0;
              if (count_q == CW'(NDIGITS - 1)) begin
                state_d = FULL;
                valid_d = 1'b1;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        FULL: begin
          // Presses are ignored while the result waits; a press in the accept cycle is lost.
          if (valid_q && out_ready) begin
            state_d = COLLECT;
            value_d = '0;
            count_d = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= COLLECT;
      value_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign value     = value_q;
  assign out_valid = valid_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: doc/dec_entry.md
Name: dec_entry

Overview:
- Operand-entry block: the inverse path of the binary-to-decimal display chain.
- User sets one decimal digit on switches and presses a key; the block accumulates digits most-significant first into a binary value.
- After NDIGITS digits it presents the binary result with a valid/ready handshake to the downstream adder/datapath.
- Sits between the board switches/keys and arithmetic blocks such as the 4-bit adders.

Parameters:
- NDIGITS, 2, number of decimal digits per operand (legal 1..3).
- VAL_W, 7, result width; must satisfy 2^VAL_W > 10^NDIGITS - 1.
- DEB_CYCLES, 500000, stable-low cycles required for a press (used only with DEC_ENTRY_DEBOUNCE_EN).

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- digit  in  4  BCD digit from switches; sampled on a press event.
- key_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50.
- clear  in  1  synchronous clear, active-high.
- out_ready  in  1  downstream accepts value.
- value  out  VAL_W  accumulated binary result.
- out_valid  out  1  value complete and stable.
- count  out  $clog2(NDIGITS+1)  digits accepted so far.
- err  out  1  last press carried an illegal digit (>9).

Behaviour:
- Reset (RESET_N low, asynchronous): state=COLLECT, value=0, count=0, out_valid=0, err=0, key synchronizer flops=1 (released).
- Key path: 2-flop synchronizer on key_n, then falling-edge detect (prev=1, now=0) gives a 1-cycle press pulse.
- Latency: key_n low before edge 1 gives press pulse after edge 2; registers update at edge 3.
- Holding the key generates exactly one press; release generates nothing.
- State COLLECT, on press:
  - digit<=9: value <= value*10 + digit (implemented as (v<<3)+(v<<1)+d, truncated to VAL_W); count++; err<=0.
  - If count reaches NDIGITS, go to FULL and set out_valid=1 on the same edge.
  - digit>9: err<=1; value and count unchanged.
- State FULL:
  - out_valid=1 and value held stable.
  - Presses are ignored, including digit checks; err holds.
  - On out_valid&&out_ready: go to COLLECT with value=0, count=0, out_valid=0 on the same edge. A press in that cycle is dropped.
- clear=1 has priority over press and handshake: state=COLLECT, value=0, count=0, out_valid=0, err=0 at the next edge.
- Reset mid-entry discards partial digits.
- No overflow is possible for legal parameters.
- out_valid never deasserts without a handshake, clear, or reset.

Optional Feature:
- Macro: DEC_ENTRY_DEBOUNCE_EN.
- Defined: after the synchronizer, the key is considered pressed only after DEB_CYCLES consecutive low samples. The counter resets on any high sample. The press pulse fires once, when the counter reaches DEB_CYCLES. Latency = 2 + DEB_CYCLES cycles.
- Undefined: no counter, no DEB_CYCLES logic; press latency as above. Benches use undefined, or DEB_CYCLES=4 when defined.

Decomposition:
- Package dec_entry_pkg:
  - state enum {COLLECT, FULL}
  - constant DEC_MAX=9
  - function mul10_add(v,d)
- Sub-module key_edge:
  - synchronizer, falling-edge detect, optional debounce
  - ports CLOCK_50, RESET_N, key_n, press

Test Plan:
- Reset, digit=1 press, digit=5 press -> count 1 then 2; out_valid=1, value=15 three cycles after second key_n fall; err=0.
- Enter 9,9 with out_ready=0, then 3 further presses -> value=99 held, out_valid stays 1, count stays 2; assert out_ready 1 cycle -> next edge out_valid=0, value=0, count=0.
- digit=12 press in COLLECT -> err=1, count/value unchanged; then digit=4 press -> err=0, value=4, count=1.
- Hold key_n low 50 cycles -> exactly one press; value changes once.
- Enter 7, then pulse clear in the same cycle as a press pulse -> value=0, count=0, err=0; the press is lost.
- Enter 3, assert RESET_N low mid-cycle -> outputs 0 immediately (asynchronous); after release, enter 4,2 -> value=42.
